// File: rtl/dma_cfg_icb_slave.sv
// DMA configuration register block on the peripheral ICB fabric.
// Holds transfer geometry, fires a one-cycle start pulse, and reports engine status.
module dma_cfg_icb_slave #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h1004_2000,
    parameter int                OFS_W     = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              icb_cmd_valid,
    output logic              icb_cmd_ready,
    input  logic [ADDR_W-1:0] icb_cmd_addr,
    input  logic              icb_cmd_read,
    input  logic [31:0]       icb_cmd_wdata,
    input  logic [3:0]        icb_cmd_wmask,
    output logic              icb_rsp_valid,
    input  logic              icb_rsp_ready,
    output logic              icb_rsp_err,
    output logic [31:0]       icb_rsp_rdata,
    output logic [31:0]       sour_addr,
    output logic [31:0]       dest_addr,
    output logic [31:0]       line_size,
    output logic [31:0]       row_size,
    output logic [31:0]       trans_matr,
    output logic              cfg_vld,
    input  logic [2:0]        dma_ctr
);

    localparam logic [OFS_W-1:0] OFS_SRC   = OFS_W'('h00);
    localparam logic [OFS_W-1:0] OFS_DST   = OFS_W'('h04);
    localparam logic [OFS_W-1:0] OFS_LINE  = OFS_W'('h08);
    localparam logic [OFS_W-1:0] OFS_ROW   = OFS_W'('h0C);
    localparam logic [OFS_W-1:0] OFS_TRANS = OFS_W'('h10);
    localparam logic [OFS_W-1:0] OFS_CTRL  = OFS_W'('h14);

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    state_t            state;
    logic              accept;
    logic              wr;
    logic              busy;
    logic              hit;
    logic              misaligned;
    logic [OFS_W-1:0]  off;
    logic              sel_src;
    logic              sel_dst;
    logic              sel_line;
    logic              sel_row;
    logic              sel_trans;
    logic              sel_ctrl;
    logic              sel_cfg;
    logic              reserved;
    logic              start_req;
    logic              busy_block;
    logic              cmd_err;
    logic              do_write;
    logic              do_start;
    logic [31:0]       rd_mux;

    // Byte-lane merge: lane i takes new data only when its enable is set.
    function automatic logic [31:0] merge(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  mask
    );
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

    // The single response buffer frees up in the same cycle it drains.
    assign icb_cmd_ready = !icb_rsp_valid || icb_rsp_ready;
    assign accept        = icb_cmd_valid && icb_cmd_ready;
    assign wr            = !icb_cmd_read;
    assign busy          = dma_ctr[2];

    assign hit        = icb_cmd_addr[ADDR_W-1:OFS_W] == BASE_ADDR[ADDR_W-1:OFS_W];
    assign off        = icb_cmd_addr[OFS_W-1:0];
    assign misaligned = icb_cmd_addr[1:0] != 2'b00;

    assign sel_src   = off == OFS_SRC;
    assign sel_dst   = off == OFS_DST;
    assign sel_line  = off == OFS_LINE;
    assign sel_row   = off == OFS_ROW;
    assign sel_trans = off == OFS_TRANS;
    assign sel_ctrl  = off == OFS_CTRL;
    assign sel_cfg   = sel_src || sel_dst || sel_line || sel_row || sel_trans;
    assign reserved  = !(sel_cfg || sel_ctrl);

    // Geometry must not move under a running engine, nor may it be restarted.
    assign start_req  = wr && sel_ctrl && icb_cmd_wdata[0] && icb_cmd_wmask[0];
    assign busy_block = busy && ((wr && sel_cfg) || start_req);
    assign cmd_err    = !hit || misaligned || reserved || busy_block;

    assign do_write = accept && !cmd_err && wr;
    assign do_start = accept && !cmd_err && start_req;

    // Read data selection; errors and writes return zero.
    always_comb begin
        rd_mux = 32'h0;
        if (icb_cmd_read && !cmd_err) begin
            unique case (1'b1)
                sel_src:   rd_mux = sour_addr;
                sel_dst:   rd_mux = dest_addr;
                sel_line:  rd_mux = line_size;
                sel_row:   rd_mux = row_size;
                sel_trans: rd_mux = trans_matr;
                sel_ctrl:  rd_mux = {29'h0, dma_ctr};
                default:   rd_mux = 32'h0;
            endcase
        end
    end

    // Configuration registers, byte-masked, updated on the accept edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sour_addr  <= 32'h0;
            dest_addr  <= 32'h0;
            line_size  <= 32'h0;
            row_size   <= 32'h0;
            trans_matr <= 32'h0;
        end else if (do_write) begin
            if (sel_src)   sour_addr  <= merge(sour_addr,  icb_cmd_wdata, icb_cmd_wmask);
            if (sel_dst)   dest_addr  <= merge(dest_addr,  icb_cmd_wdata, icb_cmd_wmask);
            if (sel_line)  line_size  <= merge(line_size,  icb_cmd_wdata, icb_cmd_wmask);
            if (sel_row)   row_size   <= merge(row_size,   icb_cmd_wdata, icb_cmd_wmask);
            if (sel_trans) trans_matr <= merge(trans_matr, icb_cmd_wdata, icb_cmd_wmask);
        end
    end

    // Response FSM with registered response fields and start pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            icb_rsp_valid <= 1'b0;
            icb_rsp_err   <= 1'b0;
            icb_rsp_rdata <= 32'h0;
            cfg_vld       <= 1'b0;
        end else begin
            cfg_vld <= do_start;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state         <= RESP;
                        icb_rsp_valid <= 1'b1;
                        icb_rsp_err   <= cmd_err;
                        icb_rsp_rdata <= rd_mux;
                    end
                end
                RESP: begin
                    if (accept) begin
                        icb_rsp_err   <= cmd_err;
                        icb_rsp_rdata <= rd_mux;
                    end else if (icb_rsp_ready) begin
                        state         <= IDLE;
                        icb_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    icb_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_cfg_icb_slave.sv
// Bench for dma_cfg_icb_slave: directed vector table, handshake corners,
// and randomized traffic against a register-map reference model.
module tb_dma_cfg_icb_slave;

    localparam logic [31:0] BASE = 32'h1004_2000;

    logic        clk;
    logic        rst_n;
    logic        icb_cmd_valid;
    logic        icb_cmd_ready;
    logic [31:0] icb_cmd_addr;
    logic        icb_cmd_read;
    logic [31:0] icb_cmd_wdata;
    logic [3:0]  icb_cmd_wmask;
    logic        icb_rsp_valid;
    logic        icb_rsp_ready;
    logic        icb_rsp_err;
    logic [31:0] icb_rsp_rdata;
    logic [31:0] sour_addr;
    logic [31:0] dest_addr;
    logic [31:0] line_size;
    logic [31:0] row_size;
    logic [31:0] trans_matr;
    logic        cfg_vld;
    logic [2:0]  dma_ctr;

    int n_cmp;
    int n_bad;

    logic [31:0] mdl [5];

    dma_cfg_icb_slave dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .icb_cmd_valid (icb_cmd_valid),
        .icb_cmd_ready (icb_cmd_ready),
        .icb_cmd_addr  (icb_cmd_addr),
        .icb_cmd_read  (icb_cmd_read),
        .icb_cmd_wdata (icb_cmd_wdata),
        .icb_cmd_wmask (icb_cmd_wmask),
        .icb_rsp_valid (icb_rsp_valid),
        .icb_rsp_ready (icb_rsp_ready),
        .icb_rsp_err   (icb_rsp_err),
        .icb_rsp_rdata (icb_rsp_rdata),
        .sour_addr     (sour_addr),
        .dest_addr     (dest_addr),
        .line_size     (line_size),
        .row_size      (row_size),
        .trans_matr    (trans_matr),
        .cfg_vld       (cfg_vld),
        .dma_ctr       (dma_ctr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  wm;
        logic [2:0]  ctr;
        logic        e;
        logic [31:0] r;
        logic        v;
    } vec_t;

    vec_t tv [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, ".src"},   sour_addr,  mdl[0]);
        chk({tag, ".dst"},   dest_addr,  mdl[1]);
        chk({tag, ".line"},  line_size,  mdl[2]);
        chk({tag, ".row"},   row_size,   mdl[3]);
        chk({tag, ".trans"}, trans_matr, mdl[4]);
    endtask

    task automatic mdl_clear();
        for (int i = 0; i < 5; i++) mdl[i] = 32'h0;
    endtask

    // Register-map reference: decides outcome from address, op and busy flag.
    task automatic mdl_xact(
        input  logic        rd,
        input  logic [31:0] a,
        input  logic [31:0] wd,
        input  logic [3:0]  wm,
        input  logic [2:0]  ctr,
        output logic        e,
        output logic [31:0] r,
        output logic        v
    );
        int  off;
        int  idx;
        bit  known;
        bit  start;
        off   = int'(a[11:0]);
        known = (a[31:12] == BASE[31:12]) && (off % 4 == 0) && (off <= 'h14);
        idx   = off / 4;
        start = !rd && idx == 5 && wd[0] && wm[0];
        e = !known;
        if (known && !rd && ctr[2] && (idx < 5 || start)) e = 1'b1;
        r = 32'h0;
        v = 1'b0;
        if (!e) begin
            if (rd) r = (idx < 5) ? mdl[idx] : {29'h0, ctr};
            else if (idx < 5) begin
                for (int b = 0; b < 4; b++)
                    if (wm[b]) mdl[idx][8*b +: 8] = wd[8*b +: 8];
            end else v = start;
        end
    endtask

    // One command with an always-ready response side; returns captured response.
    task automatic xact(
        input  logic        rd,
        input  logic [31:0] a,
        input  logic [31:0] wd,
        input  logic [3:0]  wm,
        input  logic [2:0]  ctr,
        output logic        e,
        output logic [31:0] r,
        output logic        v
    );
        icb_cmd_read  = rd;
        icb_cmd_addr  = a;
        icb_cmd_wdata = wd;
        icb_cmd_wmask = wm;
        dma_ctr       = ctr;
        icb_rsp_ready = 1'b1;
        icb_cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        icb_cmd_valid = 1'b0;
        chk("rsp_valid_lat1", {31'h0, icb_rsp_valid}, 32'h1);
        e = icb_rsp_err;
        r = icb_rsp_rdata;
        v = cfg_vld;
        @(posedge clk);
        #1;
        chk("rsp_drained", {31'h0, icb_rsp_valid}, 32'h0);
        chk("cfg_vld_drop", {31'h0, cfg_vld}, 32'h0);
    endtask

    initial begin
        logic        e;
        logic [31:0] r;
        logic        v;
        logic        me;
        logic [31:0] mr;
        logic        mv;
        logic [31:0] held;

        n_cmp = 0;
        n_bad = 0;
        mdl_clear();

        tv.push_back('{0, BASE + 'h00, 32'h8000_0000, 4'hF, 3'b000, 0, 32'h0, 0});
        tv.push_back('{1, BASE + 'h00, 32'h0,         4'h0, 3'b000, 0, 32'h8000_0000, 0});
        tv.push_back('{0, BASE + 'h04, 32'h1234_5678, 4'hF, 3'b000, 0, 32'h0, 0});
        tv.push_back('{0, BASE + 'h04, 32'hFFFF_FFFF, 4'h2, 3'b000, 0, 32'h0, 0});
        tv.push_back('{1, BASE + 'h04, 32'h0,         4'h0, 3'b000, 0, 32'h1234_FF78, 0});
        tv.push_back('{0, BASE + 'h14, 32'h1,         4'h1, 3'b000, 0, 32'h0, 1});
        tv.push_back('{0, BASE + 'h00, 32'h0000_1111, 4'hF, 3'b100, 1, 32'h0, 0});
        tv.push_back('{1, BASE + 'h00, 32'h0,         4'h0, 3'b100, 0, 32'h8000_0000, 0});
        tv.push_back('{0, BASE + 'h14, 32'h1,         4'hF, 3'b100, 1, 32'h0, 0});
        tv.push_back('{0, BASE + 'h14, 32'h0,         4'hF, 3'b100, 0, 32'h0, 0});
        tv.push_back('{0, BASE + 'h14, 32'h1,         4'hE, 3'b000, 0, 32'h0, 0});
        tv.push_back('{1, BASE + 'h20, 32'h0,         4'h0, 3'b000, 1, 32'h0, 0});
        tv.push_back('{1, BASE + 'h02, 32'h0,         4'h0, 3'b000, 1, 32'h0, 0});
        tv.push_back('{1, BASE + 'h1000, 32'h0,       4'h0, 3'b000, 1, 32'h0, 0});
        tv.push_back('{0, BASE + 'h18, 32'h5,         4'hF, 3'b000, 1, 32'h0, 0});
        tv.push_back('{1, BASE + 'h14, 32'h0,         4'h0, 3'b110, 0, 32'h6, 0});
        tv.push_back('{0, BASE + 'h10, 32'h0001_0001, 4'hF, 3'b000, 0, 32'h0, 0});
        tv.push_back('{1, BASE + 'h10, 32'h0,         4'h0, 3'b000, 0, 32'h0001_0001, 0});
        tv.push_back('{0, BASE + 'h08, 32'hDEAD_BEEF, 4'h0, 3'b000, 0, 32'h0, 0});
        tv.push_back('{1, BASE + 'h08, 32'h0,         4'h0, 3'b000, 0, 32'h0, 0});
        tv.push_back('{0, BASE + 'h0C, 32'hAABB_CCDD, 4'h5, 3'b011, 0, 32'h0, 0});
        tv.push_back('{1, BASE + 'h0C, 32'h0,         4'h0, 3'b011, 0, 32'h00BB_00DD, 0});

        rst_n         = 1'b0;
        icb_cmd_valid = 1'b0;
        icb_cmd_addr  = 32'h0;
        icb_cmd_read  = 1'b0;
        icb_cmd_wdata = 32'h0;
        icb_cmd_wmask = 4'h0;
        icb_rsp_ready = 1'b1;
        dma_ctr       = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.rsp_valid", {31'h0, icb_rsp_valid}, 32'h0);
        chk("rst.rsp_err",   {31'h0, icb_rsp_err},   32'h0);
        chk("rst.rsp_rdata", icb_rsp_rdata,          32'h0);
        chk("rst.cfg_vld",   {31'h0, cfg_vld},       32'h0);
        chk("rst.cmd_ready", {31'h0, icb_cmd_ready}, 32'h1);
        chk_regs("rst");
        rst_n = 1'b1;

        for (int i = 0; i < tv.size(); i++) begin
            xact(tv[i].rd, tv[i].a, tv[i].wd, tv[i].wm, tv[i].ctr, e, r, v);
            mdl_xact(tv[i].rd, tv[i].a, tv[i].wd, tv[i].wm, tv[i].ctr, me, mr, mv);
            chk($sformatf("vec%0d.err", i),   {31'h0, e}, {31'h0, tv[i].e});
            chk($sformatf("vec%0d.rdata", i), r,          tv[i].r);
            chk($sformatf("vec%0d.cfg_vld", i), {31'h0, v}, {31'h0, tv[i].v});
            chk_regs($sformatf("vec%0d", i));
        end

        // Stalled response: buffer full blocks new commands, fields hold.
        icb_cmd_read  = 1'b1;
        icb_cmd_addr  = BASE;
        dma_ctr       = 3'b000;
        icb_rsp_ready = 1'b0;
        icb_cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        held = mdl[0];
        chk("stall.rsp_valid", {31'h0, icb_rsp_valid}, 32'h1);
        chk("stall.rdata0",    icb_rsp_rdata,          held);
        icb_cmd_read  = 1'b0;
        icb_cmd_addr  = BASE + 'h04;
        icb_cmd_wdata = 32'hCAFE_BABE;
        icb_cmd_wmask = 4'hF;
        #1;
        chk("stall.cmd_ready", {31'h0, icb_cmd_ready}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("stall.hold_valid", {31'h0, icb_rsp_valid}, 32'h1);
            chk("stall.hold_rdata", icb_rsp_rdata,          held);
            chk("stall.hold_err",   {31'h0, icb_rsp_err},   32'h0);
            chk("stall.hold_ready", {31'h0, icb_cmd_ready}, 32'h0);
            chk_regs("stall");
        end
        icb_rsp_ready = 1'b1;
        #1;
        chk("b2b.cmd_ready", {31'h0, icb_cmd_ready}, 32'h1);
        @(posedge clk);
        #1;
        icb_cmd_valid = 1'b0;
        mdl_xact(1'b0, BASE + 'h04, 32'hCAFE_BABE, 4'hF, 3'b000, me, mr, mv);
        chk("b2b.rsp_valid", {31'h0, icb_rsp_valid}, 32'h1);
        chk("b2b.err",       {31'h0, icb_rsp_err},   {31'h0, me});
        chk("b2b.rdata",     icb_rsp_rdata,          mr);
        chk_regs("b2b");
        @(posedge clk);
        #1;
        chk("b2b.drain", {31'h0, icb_rsp_valid}, 32'h0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 300; n++) begin
            logic        rd;
            logic [31:0] a;
            logic [31:0] wd;
            logic [3:0]  wm;
            logic [2:0]  ctr;
            int          kind;
            int          idx;
            kind = $urandom_range(0, 9);
            idx  = $urandom_range(0, 5);
            rd   = 1'($urandom_range(0, 2) == 0);
            wd   = $urandom;
            wm   = 4'($urandom);
            ctr  = 3'($urandom);
            if ($urandom_range(0, 3) != 0) ctr[2] = 1'b0;
            if ($urandom_range(0, 3) == 0) wm = 4'hF;
            if (kind <= 6)      a = BASE + 32'(idx * 4);
            else if (kind == 7) a = BASE + 32'('h18 + 4 * $urandom_range(0, 1000));
            else if (kind == 8) a = BASE + 32'(idx * 4 + $urandom_range(1, 3));
            else                a = (BASE ^ (32'h1 << $urandom_range(12, 31))) + 32'(idx * 4);
            xact(rd, a, wd, wm, ctr, e, r, v);
            mdl_xact(rd, a, wd, wm, ctr, me, mr, mv);
            chk($sformatf("rnd%0d.err", n),     {31'h0, e}, {31'h0, me});
            chk($sformatf("rnd%0d.rdata", n),   r,          mr);
            chk($sformatf("rnd%0d.cfg_vld", n), {31'h0, v}, {31'h0, mv});
            chk_regs($sformatf("rnd%0d", n));
        end

        // Make sure registers are non-zero before the mid-transaction reset.
        xact(1'b0, BASE + 'h10, 32'h5A5A_A5A5, 4'hF, 3'b000, e, r, v);
        mdl_xact(1'b0, BASE + 'h10, 32'h5A5A_A5A5, 4'hF, 3'b000, me, mr, mv);
        chk("prerst.trans", trans_matr, 32'h5A5A_A5A5);

        // Reset while a response is stalled: it must vanish.
        icb_cmd_read  = 1'b1;
        icb_cmd_addr  = BASE + 'h14;
        dma_ctr       = 3'b001;
        icb_rsp_ready = 1'b0;
        icb_cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        icb_cmd_valid = 1'b0;
        chk("midrst.pre_valid", {31'h0, icb_rsp_valid}, 32'h1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        mdl_clear();
        chk("midrst.rsp_valid", {31'h0, icb_rsp_valid}, 32'h0);
        chk("midrst.rsp_rdata", icb_rsp_rdata,          32'h0);
        chk("midrst.cfg_vld",   {31'h0, cfg_vld},       32'h0);
        chk_regs("midrst");
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("midrst.no_late_rsp", {31'h0, icb_rsp_valid}, 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
